// File: rtl/eth_tx_framer_pkg.sv
// Shared definitions for the TX framer and its neighbours (state encoding, CRC constants, Ethernet lengths).
package eth_tx_framer_pkg;

    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam int          ETH_MIN_LEN = 60;
    localparam int          ETH_MAX_LEN = 1514;
    localparam int          CNT_W       = 11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_DROP = 3'd2,
        S_PAD  = 3'd3,
        S_FCS  = 3'd4
    } state_t;

endpackage

// File: rtl/eth_tx_framer_if.sv
// Byte-stream input and TX FIFO write-side signals of the framer.
interface eth_tx_framer_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [7:0] fifo_din;
    logic       fifo_EOD_in;
    logic       fifo_wren;
    logic       fifo_full;

    // Environment side: frame source and FIFO status.
    modport master (
        output s_data, s_valid, s_last, fifo_full,
        input  s_ready, fifo_din, fifo_EOD_in, fifo_wren
    );

    // Framer side.
    modport slave (
        input  s_data, s_valid, s_last, fifo_full,
        output s_ready, fifo_din, fifo_EOD_in, fifo_wren
    );

endinterface

// File: rtl/eth_tx_framer_crc32_d8.sv
// One-byte step of the reflected IEEE 802.3 CRC-32; data consumed LSB first.
module crc32_d8
    import eth_tx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Unrolled bit-serial LFSR: eight shifts per byte.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i])
                crc_out = (crc_out >> 1) ^ CRC_POLY;
            else
                crc_out = crc_out >> 1;
        end
    end

endmodule

// File: rtl/my_bin2gray.sv
// Binary to gray-code conversion for counters crossing into other domains.
module my_bin2gray #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: passes frame bytes to the TX FIFO, zero-pads to MIN_LEN,
// truncates at MAX_LEN and appends the CRC-32 FCS (LSB byte first, EOD on the last).
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic                  REF_CLK,
    input  logic                  rst,
    eth_tx_framer_if.slave        bus,
    output logic [15:0]           frame_count_gray,
    output logic [15:0]           trunc_count_gray
);

    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0]      crc_q, crc_d, crc_nxt, fcs_word;
    logic [7:0]       crc_byte;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      frame_q, frame_d, trunc_q, trunc_d;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign fcs_word = ~crc_q;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (crc_byte),
        .crc_out (crc_nxt)
    );

    // Next state, datapath updates and the combinational FIFO/stream outputs.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        crc_d           = crc_q;
        idx_d           = idx_q;
        frame_d         = frame_q;
        trunc_d         = trunc_q;
        crc_byte        = bus.s_data;
        bus.s_ready     = 1'b0;
        bus.fifo_wren   = 1'b0;
        bus.fifo_din    = 8'h00;
        bus.fifo_EOD_in = 1'b0;

        case (state_q)
            S_IDLE, S_DATA: begin
                // Idle counts are 0 and CRC is CRC_INIT, so the first byte shares the data path.
                bus.s_ready = ~bus.fifo_full;
                if (bus.s_valid && !bus.fifo_full) begin
                    bus.fifo_wren = 1'b1;
                    bus.fifo_din  = bus.s_data;
                    crc_d         = crc_nxt;
                    cnt_d         = cnt_inc;
                    if (bus.s_last)
                        state_d = (cnt_inc < MIN_L) ? S_PAD : S_FCS;
                    else if (cnt_inc == MAX_L) begin
                        state_d = S_DROP;
                        trunc_d = trunc_q + 16'd1;
                    end else
                        state_d = S_DATA;
                end
            end
            S_DROP: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid && bus.s_last)
                    state_d = S_FCS;
            end
            S_PAD: begin
                crc_byte = 8'h00;
                if (!bus.fifo_full) begin
                    bus.fifo_wren = 1'b1;
                    crc_d         = crc_nxt;
                    cnt_d         = cnt_inc;
                    if (cnt_inc == MIN_L)
                        state_d = S_FCS;
                end
            end
            S_FCS: begin
                if (!bus.fifo_full) begin
                    bus.fifo_wren   = 1'b1;
                    bus.fifo_din    = fcs_word[{idx_q, 3'b000} +: 8];
                    bus.fifo_EOD_in = (idx_q == 2'd3);
                    idx_d           = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        frame_d = frame_q + 16'd1;
                        crc_d   = CRC_INIT;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // No handshake or write while reset is held, so the FIFO sees nothing from a dying frame.
        if (rst) begin
            bus.s_ready     = 1'b0;
            bus.fifo_wren   = 1'b0;
            bus.fifo_din    = 8'h00;
            bus.fifo_EOD_in = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge REF_CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            idx_q   <= 2'd0;
            frame_q <= 16'd0;
            trunc_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            trunc_q <= trunc_d;
        end
    end

    my_bin2gray #(.WIDTH(16)) u_frame_gray (
        .bin  (frame_q),
        .gray (frame_count_gray)
    );

    my_bin2gray #(.WIDTH(16)) u_trunc_gray (
        .bin  (trunc_q),
        .gray (trunc_count_gray)
    );

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized self-checking bench for eth_tx_framer against a frame-level reference model.
module tb_eth_tx_framer;
    import eth_tx_framer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last, fifo_full;

    eth_tx_framer_if if_def ();
    eth_tx_framer_if if_np ();
    eth_tx_framer_if if_tr ();

    assign if_def.s_data = s_data;  assign if_def.s_valid = s_valid;
    assign if_def.s_last = s_last;  assign if_def.fifo_full = fifo_full;
    assign if_np.s_data  = s_data;  assign if_np.s_valid  = s_valid;
    assign if_np.s_last  = s_last;  assign if_np.fifo_full  = fifo_full;
    assign if_tr.s_data  = s_data;  assign if_tr.s_valid  = s_valid;
    assign if_tr.s_last  = s_last;  assign if_tr.fifo_full  = fifo_full;

    logic [15:0] fc_def, tc_def, fc_np, tc_np, fc_tr, tc_tr;

    eth_tx_framer #(.MIN_LEN(60), .MAX_LEN(1514)) dut_def (
        .REF_CLK(clk), .rst(rst), .bus(if_def),
        .frame_count_gray(fc_def), .trunc_count_gray(tc_def));
    eth_tx_framer #(.MIN_LEN(0), .MAX_LEN(1514)) dut_np (
        .REF_CLK(clk), .rst(rst), .bus(if_np),
        .frame_count_gray(fc_np), .trunc_count_gray(tc_np));
    eth_tx_framer #(.MIN_LEN(16), .MAX_LEN(20)) dut_tr (
        .REF_CLK(clk), .rst(rst), .bus(if_tr),
        .frame_count_gray(fc_tr), .trunc_count_gray(tc_tr));

    // Observed DUT: 0 = default, 1 = no padding, 2 = MAX_LEN 20
    int          sel;
    logic        o_ready, o_wren, o_eod;
    logic [7:0]  o_din;
    logic [15:0] o_fc, o_tc;

    always_comb begin
        o_ready = if_def.s_ready; o_wren = if_def.fifo_wren; o_eod = if_def.fifo_EOD_in;
        o_din = if_def.fifo_din;  o_fc = fc_def; o_tc = tc_def;
        if (sel == 1) begin
            o_ready = if_np.s_ready; o_wren = if_np.fifo_wren; o_eod = if_np.fifo_EOD_in;
            o_din = if_np.fifo_din;  o_fc = fc_np; o_tc = tc_np;
        end else if (sel == 2) begin
            o_ready = if_tr.s_ready; o_wren = if_tr.fifo_wren; o_eod = if_tr.fifo_EOD_in;
            o_din = if_tr.fifo_din;  o_fc = fc_tr; o_tc = tc_tr;
        end
    end

    int          vectors = 0;
    int          errors  = 0;
    int          full_pct;
    int          viol;
    logic [8:0]  cap[$];
    logic [8:0]  exp[$];
    int          acc_wr[$];

    // Textbook reflected CRC-32 over a whole byte sequence (with final complement).
    function automatic logic [31:0] crc_ref(input logic [7:0] d[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (d[i]) begin
            c = c ^ {24'h0, d[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Expected FIFO writes for one frame: truncate, pad, append FCS LSB byte first.
    function automatic void model_frame(input logic [7:0] fr[$], input int minl, input int maxl);
        logic [7:0]  b[$];
        logic [31:0] fcs;
        b = fr;
        while (b.size() > maxl) void'(b.pop_back());
        while (b.size() < minl) b.push_back(8'h00);
        fcs = crc_ref(b);
        foreach (b[i]) exp.push_back({1'b0, b[i]});
        for (int k = 0; k < 4; k++)
            exp.push_back({(k == 3), 8'(fcs >> (8 * k))});
    endfunction

    function automatic logic [15:0] gray(input int n);
        logic [15:0] v;
        v = 16'(n);
        return v ^ (v >> 1);
    endfunction

    // Presents bytes one per handshake, records every FIFO write, stops after n_eod EODs
    // (or once stop_wr writes have been captured when stop_wr > 0).
    task automatic drive(input logic [7:0] bytes[$], input bit lasts[$], input int n_eod,
                         input int stop_wr, output int n_acc);
        int eods, budget;
        n_acc = 0; eods = 0; budget = 0;
        while (eods < n_eod && budget < 4000 && !(stop_wr > 0 && cap.size() >= stop_wr)) begin
            @(negedge clk);
            fifo_full = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
            if (n_acc < bytes.size()) begin
                s_valid = 1'b1; s_data = bytes[n_acc]; s_last = lasts[n_acc];
            end else begin
                s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
            end
            #1;
            if (o_wren) begin
                if (fifo_full) viol++;
                cap.push_back({o_eod, o_din});
                if (o_eod) eods++;
            end
            if (s_valid && o_ready) begin
                n_acc++;
                acc_wr.push_back(cap.size());
            end
            budget++;
        end
        vectors++;
        if (budget >= 4000) begin
            errors++;
            $display("FAIL drive_timeout: eods seen %0d, required %0d", eods, n_eod);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cap.delete(); exp.delete(); acc_wr.delete();
        viol = 0; full_pct = 0;
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        rst = 1'b1; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0; fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", o_ready); end
        vectors++; if (o_wren !== 1'b0)  begin errors++; $display("FAIL reset_wren got %b want 0", o_wren); end
        vectors++; if (o_eod !== 1'b0)   begin errors++; $display("FAIL reset_eod got %b want 0", o_eod); end
        vectors++; if (o_din !== 8'h00)  begin errors++; $display("FAIL reset_din got %h want 00", o_din); end
        vectors++; if (o_fc !== 16'h0)   begin errors++; $display("FAIL reset_frame_cnt got %h want 0000", o_fc); end
        vectors++; if (o_tc !== 16'h0)   begin errors++; $display("FAIL reset_trunc_cnt got %h want 0000", o_tc); end
        s_valid = 1'b0; rst = 1'b0;
        #1;
        vectors++; if (o_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", o_ready); end
    endtask

    task automatic test_check_vector();
        logic [7:0] b[$];
        bit         l[$];
        logic [7:0] fcs_b[4];
        int         n;
        do_reset();
        sel = 1;
        for (int i = 0; i < 9; i++) begin b.push_back(8'h31 + 8'(i)); l.push_back(i == 8); end
        fcs_b[0] = 8'h26; fcs_b[1] = 8'h39; fcs_b[2] = 8'hF4; fcs_b[3] = 8'hCB;
        foreach (b[i]) exp.push_back({1'b0, b[i]});
        for (int k = 0; k < 4; k++) exp.push_back({(k == 3), fcs_b[k]});
        drive(b, l, 1, 0, n);
        @(negedge clk); #1;
        vectors++; if (cap.size() !== exp.size()) begin errors++; $display("FAIL chk_len got %0d want %0d", cap.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
            vectors++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL chk_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
        end
        vectors++; if (o_fc !== 16'h0001) begin errors++; $display("FAIL chk_frame_cnt got %h want 0001", o_fc); end
    endtask

    task automatic test_pad();
        logic [7:0] b[$];
        bit         l[$];
        int         n;
        do_reset();
        sel = 0;
        for (int i = 0; i < 14; i++) begin b.push_back(8'($urandom_range(0, 255))); l.push_back(i == 13); end
        model_frame(b, 60, 1514);
        drive(b, l, 1, 0, n);
        @(negedge clk); #1;
        vectors++; if (cap.size() !== 64) begin errors++; $display("FAIL pad_len got %0d want 64", cap.size()); end
        for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
            vectors++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL pad_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
        end
        vectors++; if (o_fc !== gray(1)) begin errors++; $display("FAIL pad_frame_cnt got %h want %h", o_fc, gray(1)); end
    endtask

    task automatic test_trunc();
        logic [7:0] b[$];
        bit         l[$];
        int         n;
        do_reset();
        sel = 2;
        for (int i = 0; i < 30; i++) begin b.push_back(8'($urandom_range(0, 255))); l.push_back(i == 29); end
        model_frame(b, 16, 20);
        drive(b, l, 1, 0, n);
        @(negedge clk); #1;
        vectors++; if (n !== 30) begin errors++; $display("FAIL trunc_accepted got %0d want 30", n); end
        vectors++; if (cap.size() !== exp.size()) begin errors++; $display("FAIL trunc_len got %0d want %0d", cap.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
            vectors++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL trunc_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
        end
        vectors++; if (o_tc !== gray(1)) begin errors++; $display("FAIL trunc_cnt got %h want %h", o_tc, gray(1)); end
        vectors++; if (o_fc !== gray(1)) begin errors++; $display("FAIL trunc_frame_cnt got %h want %h", o_fc, gray(1)); end
    endtask

    task automatic test_stall();
        logic [7:0] b[$];
        bit         l[$];
        int         n, len;
        do_reset();
        sel = 0;
        full_pct = 40;
        for (int f = 0; f < 4; f++) begin
            b.delete(); l.delete(); cap.delete(); exp.delete();
            len = (f == 0) ? 5 : $urandom_range(20, 100);
            for (int i = 0; i < len; i++) begin b.push_back(8'($urandom_range(0, 255))); l.push_back(i == len - 1); end
            model_frame(b, 60, 1514);
            drive(b, l, 1, 0, n);
            vectors++; if (cap.size() !== exp.size()) begin errors++; $display("FAIL stall_len[%0d] got %0d want %0d", f, cap.size(), exp.size()); end
            for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
                vectors++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL stall_byte[%0d][%0d] got %h want %h", f, i, cap[i], exp[i]); end
            end
        end
        full_pct = 0;
        @(negedge clk); fifo_full = 1'b0; #1;
        vectors++; if (viol !== 0) begin errors++; $display("FAIL stall_write_while_full got %0d want 0", viol); end
        vectors++; if (o_fc !== gray(4)) begin errors++; $display("FAIL stall_frame_cnt got %h want %h", o_fc, gray(4)); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[$];
        bit         l[$];
        logic [7:0] one[$];
        int         n;
        do_reset();
        sel = 0;
        for (int i = 0; i < 2; i++) begin b.push_back(8'($urandom_range(0, 255))); l.push_back(1'b1); end
        for (int i = 0; i < 2; i++) begin one.delete(); one.push_back(b[i]); model_frame(one, 60, 1514); end
        drive(b, l, 2, 0, n);
        @(negedge clk); #1;
        vectors++; if (cap.size() !== 128) begin errors++; $display("FAIL b2b_len got %0d want 128", cap.size()); end
        for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
            vectors++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
        end
        vectors++; if (acc_wr.size() !== 2) begin errors++; $display("FAIL b2b_accepts got %0d want 2", acc_wr.size()); end
        if (acc_wr.size() == 2) begin
            vectors++; if (acc_wr[1] !== 65) begin errors++; $display("FAIL b2b_second_accept_at got %0d want 65", acc_wr[1]); end
        end
        vectors++; if (o_fc !== gray(2)) begin errors++; $display("FAIL b2b_frame_cnt got %h want %h", o_fc, gray(2)); end
    endtask

    task automatic test_reset_pad();
        logic [7:0] b[$];
        bit         l[$];
        int         n;
        do_reset();
        sel = 0;
        for (int i = 0; i < 3; i++) begin b.push_back(8'($urandom_range(0, 255))); l.push_back(i == 2); end
        drive(b, l, 1, 10, n);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        vectors++; if (o_wren !== 1'b0)  begin errors++; $display("FAIL rstpad_wren got %b want 0", o_wren); end
        vectors++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rstpad_ready got %b want 0", o_ready); end
        vectors++; if (o_din !== 8'h00)  begin errors++; $display("FAIL rstpad_din got %h want 00", o_din); end
        vectors++; if (o_eod !== 1'b0)   begin errors++; $display("FAIL rstpad_eod got %b want 0", o_eod); end
        rst = 1'b0;
        cap.delete(); exp.delete(); b.delete(); l.delete();
        for (int i = 0; i < 10; i++) begin b.push_back(8'($urandom_range(0, 255))); l.push_back(i == 9); end
        model_frame(b, 60, 1514);
        drive(b, l, 1, 0, n);
        @(negedge clk); #1;
        vectors++; if (cap.size() !== exp.size()) begin errors++; $display("FAIL rstpad_len got %0d want %0d", cap.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < cap.size(); i++) begin
            vectors++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL rstpad_byte[%0d] got %h want %h", i, cap[i], exp[i]); end
        end
        vectors++; if (o_fc !== gray(1)) begin errors++; $display("FAIL rstpad_frame_cnt got %h want %h", o_fc, gray(1)); end
    endtask

    initial begin
        sel = 0; rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; fifo_full = 1'b0;
        full_pct = 0; viol = 0;
        test_reset();
        test_check_vector();
        test_pad();
        test_trunc();
        test_stall();
        test_back_to_back();
        test_reset_pad();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
